alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Front-panel sequencer for the board ALU datapath. Synchronises the four push buttons and edge-detects them, with optional debounce. Maintains the opcode and operand registers and issues single-operation requests to the ALU over a start/done handshake. Latches the result and provides a 16-bit word to the 7-segment scan driver in the top level.

Parameters:
DW, 8, operand width; A = sw[2*DW-1:DW], B = sw[DW-1:0]
OPW, 3, opcode width; opcode wraps modulo 2^OPW
DB_CYCLES, 500000, stable-level cycles required to accept a button change (debounce build only)
TIMEOUT, 255, max cycles in WAIT before error; counter width is clog2(TIMEOUT+1)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
sw  in  2*DW  operand switches
btn  in  4  raw buttons: [0] next opcode, [1] load operands, [2] execute, [3] toggle display
alu_a  out  DW  operand A register
alu_b  out  DW  operand B register
alu_op  out  OPW  opcode register
alu_start  out  1  one-cycle request pulse
alu_done  in  1  ALU completion, sampled in WAIT only
alu_res  in  2*DW  ALU result, valid with alu_done
busy  out  1  high in ISSUE and WAIT
err  out  1  sticky timeout flag
disp_data  out  16  word for the 7-segment driver

Behaviour:
- Reset: alu_a=0, alu_b=0, alu_op=0, alu_start=0, busy=0, err=0, result register=0, disp_mode=0, sync/debounce state=0, FSM=IDLE.
- Each btn bit passes through a 2-flop synchroniser, then the debounce filter, then a rising-edge detector. This gives a one-cycle press pulse. Latency from raw edge to pulse is 3 cycles without debounce.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: press[0] sets alu_op <= alu_op+1 (wrap). press[1] sets alu_a/alu_b from sw. press[2] goes to ISSUE and clears err. press[3] toggles disp_mode.
- Multiple presses in the same cycle: all enabled actions apply. If press[1] and press[2] coincide, the operands load first, so the new operands are the ones issued.
- ISSUE: alu_start=1 for exactly one cycle, then go to WAIT. The timeout counter is cleared.
- WAIT: on alu_done, latch alu_res and go to DONE. Otherwise increment the counter. When counter==TIMEOUT, set err=1, keep the previous result, and go to IDLE.
- DONE: set disp_mode=1 (result shown), then go to IDLE the next cycle.
- In ISSUE and WAIT, press[0], press[1] and press[2] are ignored; press[3] is still honoured. alu_a, alu_b and alu_op stay stable from ISSUE until the FSM leaves WAIT.
- alu_done outside WAIT is ignored.
- disp_data is combinational from registers:
  - err=1 gives 16'hEEEE.
  - Otherwise disp_mode=0 gives the zero-extended {alu_a, alu_b} (low 16 bits).
  - Otherwise it gives result[15:0].
- Reset asserted mid-operation aborts immediately to the reset values. alu_start must never be high during or on the first cycle after reset.

Optional Feature:
DEBOUNCE_EN. When defined, each synchronised button feeds a per-bit counter. The filtered level changes only after the input has differed from it for DB_CYCLES consecutive cycles, and any bounce restarts the counter. Press latency becomes DB_CYCLES+3 cycles. When undefined, the filter is a wire: the synchronised level goes straight to the edge detector. This build is used for simulation, where buttons toggle every 10 ns.

Test Plan:
1. No DEBOUNCE_EN. Pulse btn[0] high 10 ns / low 10 ns, 16 times, with clk period 20 ns and each pulse spanning at least one edge. Required: alu_op steps 0→7→0→…, ending at 0 after 16 presses (two wraps). disp_data is unchanged.
2. Set sw=16'h3A05, press btn[1]. Required: alu_a=8'h3A, alu_b=8'h05, disp_data=16'h3A05.
3. Press btn[2]; the bench's ALU model asserts alu_done with alu_res=16'h003F four cycles after alu_start. Required: exactly one alu_start pulse, busy high for 5 cycles, then disp_data=16'h003F.
4. Press btn[2] with alu_done never asserted. Required: err=1 after TIMEOUT+1 WAIT cycles and disp_data=16'hEEEE. A following btn[2] press clears err.
5. During WAIT, press btn[0] and btn[1] with sw changed. Required: alu_op, alu_a and alu_b are unchanged. A btn[3] press toggles disp_mode.
6. With DEBOUNCE_EN and DB_CYCLES=4, apply a 3-cycle glitch on btn[0]. Required: no increment. Then hold btn[0] for 10 cycles. Required: exactly one increment.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- front-panel sequencer for the board ALU datapath.
//
// Synchronises and edge-detects four push buttons, keeps the opcode and
// operand registers, issues one ALU operation per execute press over a
// start/done handshake, latches the result and builds the 16-bit word for
// the 7-segment scan driver.
//
// Build option: define DEBOUNCE_EN to insert a per-button stable-level
// filter (DB_CYCLES cycles) between the synchroniser and the edge detector.
// Without it the synchronised level feeds the edge detector directly.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sw         operand switches, A = sw[2*DW-1:DW], B = sw[DW-1:0]
//   btn        raw buttons: [0] next opcode, [1] load operands,
//              [2] execute, [3] toggle display
//   alu_a/b    operand registers
//   alu_op     opcode register (wraps modulo 2^OPW)
//   alu_start  one-cycle request pulse
//   alu_done   ALU completion, honoured only while waiting
//   alu_res    ALU result, valid with alu_done
//   busy       high while a request is being issued or awaited
//   err        sticky timeout flag, cleared by the next execute press
//   disp_data  word for the 7-segment driver
module alu_seq_ctrl #(
    parameter int DW        = 8,
    parameter int OPW       = 3,
    parameter int DB_CYCLES = 500000,
    parameter int TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2*DW-1:0] sw,
    input  logic [3:0]      btn,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [OPW-1:0]  alu_op,
    output logic            alu_start,
    input  logic            alu_done,
    input  logic [2*DW-1:0] alu_res,
    output logic            busy,
    output logic            err,
    output logic [15:0]     disp_data
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    // ---------------- button conditioning ----------------
    logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0] filt;
    logic [3:0] filt_prev_q, filt_prev_d;
    logic [3:0] press_q, press_d;

    always_comb begin
        sync1_d     = btn;
        sync2_d     = sync1_q;
        filt_prev_d = filt;
        // Registered rising edge: one-cycle press pulse, 3 cycles after the raw edge
        press_d     = filt & ~filt_prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_prev_q <= '0;
            press_q     <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_prev_q <= filt_prev_d;
            press_q     <= press_d;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DBW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

    logic [DBW-1:0] db_cnt_q [4];
    logic [DBW-1:0] db_cnt_d [4];
    logic [3:0]     filt_q, filt_d;

    // The filtered level follows the input only after it has differed for
    // DB_CYCLES consecutive cycles; agreeing again restarts the count.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign filt = filt_q;
`else
    // DB_CYCLES only shapes the debounce build; this block just anchors it.
    if (DB_CYCLES < 1) begin : g_db_cycles_unused
    end

    assign filt = sync2_q;
`endif

    // ---------------- sequencer ----------------
    state_t          state_q, state_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [2*DW-1:0] res_q, res_d;
    logic            err_q, err_d;
    logic            disp_mode_q, disp_mode_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        err_d       = err_q;
        disp_mode_d = disp_mode_q;
        tmo_cnt_d   = tmo_cnt_q;
        alu_start   = 1'b0;
        busy        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // All simultaneous presses apply; operands loaded in the same
                // cycle as execute are therefore the ones issued.
                if (press_q[0]) op_d = op_q + 1'b1;
                if (press_q[1]) begin
                    a_d = sw[2*DW-1:DW];
                    b_d = sw[DW-1:0];
                end
                if (press_q[3]) disp_mode_d = ~disp_mode_q;
                if (press_q[2]) begin
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_start = 1'b1;
                busy      = 1'b1;
                tmo_cnt_d = '0;
                if (press_q[3]) disp_mode_d = ~disp_mode_q;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (press_q[3]) disp_mode_d = ~disp_mode_q;
                if (alu_done) begin
                    res_d   = alu_res;
                    state_d = ST_DONE;
                end else if (tmo_cnt_q == TW'(TIMEOUT)) begin
                    // Give up: flag the error and keep the previous result
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                disp_mode_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            disp_mode_q <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            err_q       <= err_d;
            disp_mode_q <= disp_mode_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // ---------------- display word ----------------
    always_comb begin
        if (err_q)             disp_data = 16'hEEEE;
        else if (!disp_mode_q) disp_data = 16'({a_q, b_q});
        else                   disp_data = 16'(res_q);
    end

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
`timescale 1ns/1ps
module tb_alu_seq_ctrl;
    localparam int DW  = 8;
    localparam int OPW = 3;
    localparam int DBC = 4;
    localparam int TO  = 255;
`ifdef DEBOUNCE_EN
    localparam int PX = DBC;
`else
    localparam int PX = 0;
`endif
    localparam int TAIL = 5 + PX;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] sw    = '0;
    logic [3:0]  btn   = '0;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_start, alu_done, busy, err;
    logic [15:0] alu_res, disp_data;

    logic        model_done = 1'b0, stray_done = 1'b0;
    logic [15:0] model_res  = '0,   stray_res  = '0;
    assign alu_done = model_done | stray_done;
    assign alu_res  = model_done ? model_res : stray_res;

    alu_seq_ctrl #(.DW(DW), .OPW(OPW), .DB_CYCLES(DBC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_res(alu_res), .busy(busy), .err(err),
        .disp_data(disp_data)
    );

    always #10 clk = ~clk;

    // Reference model: panel state as plain values
    int          m_op = 0;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [15:0] m_res = '0;
    bit          m_err = 0, m_mode = 0;

    int checks = 0, failures = 0;

    function automatic logic [15:0] exp_disp();
        if (m_err)  return 16'hEEEE;
        if (m_mode) return m_res;
        return {m_a, m_b};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_op"},   32'(alu_op), 32'(m_op));
        check_eq({tag, "_a"},    32'(alu_a), 32'(m_a));
        check_eq({tag, "_b"},    32'(alu_b), 32'(m_b));
        check_eq({tag, "_err"},  32'(err), 32'(m_err));
        check_eq({tag, "_disp"}, 32'(disp_data), 32'(exp_disp()));
    endtask

    // Activity monitor
    int start_cnt = 0, busy_cnt = 0;
    always @(negedge clk) begin
        if (alu_start === 1'b1) start_cnt++;
        if (busy === 1'b1)      busy_cnt++;
    end

    // ALU model: answers alu_lat cycles after the start pulse (never if < 1)
    int          alu_lat = -1;
    logic [15:0] alu_ret = '0;
    logic [7:0]  seen_a = '0, seen_b = '0;
    logic [2:0]  seen_op = '0;
    initial begin : alu_model
        forever begin
            @(posedge clk);
            #1;
            if (alu_start === 1'b1) begin
                seen_a  = alu_a;
                seen_b  = alu_b;
                seen_op = alu_op;
                if (alu_lat > 0) begin
                    repeat (alu_lat) @(posedge clk);
                    #1;
                    model_res  = alu_ret;
                    model_done = 1'b1;
                    @(posedge clk);
                    #1;
                    model_done = 1'b0;
                end
            end
        end
    end

    task automatic press(input logic [3:0] m, input int tail);
        @(negedge clk);
        #5 btn = m;
`ifdef DEBOUNCE_EN
        repeat (DBC + 1) @(negedge clk);
        #5;
`else
        #10;
`endif
        btn = '0;
        repeat (tail) @(negedge clk);
    endtask

    task automatic wait_busy(input logic lvl, input int bound);
        int n = 0;
        while (busy !== lvl && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One execute press (with any other buttons in mask), run to completion
    task automatic exec(input logic [3:0] mask, input int lat, input logic [15:0] res);
        int s0, b0, exp_busy;
        alu_lat = lat;
        alu_ret = res;
        s0 = start_cnt;
        b0 = busy_cnt;
        if (mask[0]) m_op = (m_op + 1) % 8;
        if (mask[1]) begin m_a = sw[15:8]; m_b = sw[7:0]; end
        if (mask[3]) m_mode = !m_mode;
        press(mask | 4'b0100, 0);
        wait_busy(1'b1, 20 + PX);
        check_eq("busy_rise", 32'(busy), 32'd1);
        check_eq("err_clr_on_issue", 32'(err), 32'd0);
        wait_busy(1'b0, TO + 20);
        check_eq("busy_fall", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        if (lat >= 1 && lat <= TO + 1) begin
            m_res = res; m_mode = 1; m_err = 0; exp_busy = lat + 1;
        end else begin
            m_err = 1; exp_busy = TO + 2;
        end
        check_eq("start_pulses", 32'(start_cnt - s0), 32'd1);
        check_eq("busy_cycles", 32'(busy_cnt - b0), 32'(exp_busy));
        check_eq("issued_a", 32'(seen_a), 32'(m_a));
        check_eq("issued_b", 32'(seen_b), 32'(m_b));
        check_eq("issued_op", 32'(seen_op), 32'(m_op));
        check_state("exec");
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0]  mask;
        logic [15:0] r;
        int s0, b0;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_start", 32'(alu_start), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_state("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_start", 32'(alu_start), 32'd0);

        // Opcode stepping through two wraps
        for (int i = 0; i < 16; i++) begin
            press(4'b0001, TAIL);
            m_op = (m_op + 1) % 8;
            check_eq("op_step", 32'(alu_op), 32'(m_op));
        end
        check_eq("op_two_wraps", 32'(alu_op), 32'd0);
        check_eq("t1_disp", 32'(disp_data), 32'(exp_disp()));

        // Operand load
        sw = 16'h3A05;
        press(4'b0010, TAIL);
        m_a = 8'h3A; m_b = 8'h05;
        check_eq("load_disp", 32'(disp_data), 32'h3A05);
        check_state("load");

        // Normal operation, ALU answers 4 cycles after start
        exec(4'b0100, 4, 16'h003F);
        check_eq("result_disp", 32'(disp_data), 32'h003F);

        // alu_done while idle must be ignored
        stray_res = 16'hBEEF;
        @(negedge clk); stray_done = 1'b1;
        @(negedge clk); stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check_state("stray_done");

        // Timeout, then the next execute clears err
        exec(4'b0100, -1, 16'h0000);
        check_eq("timeout_disp", 32'(disp_data), 32'hEEEE);
        r = 16'($urandom);
        exec(4'b0100, 3, r);
        check_eq("err_cleared", 32'(err), 32'd0);

        // Load and execute in the same cycle: new operands are issued
        sw = 16'($urandom);
        exec(4'b0110, 2, 16'($urandom));

        // Presses during WAIT
        r = 16'($urandom);
        alu_lat = 80; alu_ret = r;
        s0 = start_cnt; b0 = busy_cnt;
        press(4'b0100, 0);
        wait_busy(1'b1, 20 + PX);
        check_eq("w_busy", 32'(busy), 32'd1);
        sw = ~{m_a, m_b};
        press(4'b0001, TAIL);
        press(4'b0010, TAIL);
        check_eq("w_still_busy", 32'(busy), 32'd1);
        check_eq("w_op", 32'(alu_op), 32'(m_op));
        check_eq("w_a", 32'(alu_a), 32'(m_a));
        check_eq("w_b", 32'(alu_b), 32'(m_b));
        press(4'b1000, TAIL);
        m_mode = !m_mode;
        check_eq("w_toggle_disp", 32'(disp_data), 32'(exp_disp()));
        wait_busy(1'b0, TO + 20);
        repeat (2) @(negedge clk);
        m_res = r; m_mode = 1;
        check_eq("w_start_pulses", 32'(start_cnt - s0), 32'd1);
        check_eq("w_busy_cycles", 32'(busy_cnt - b0), 32'd81);
        check_state("w_end");

        // Randomised panel activity
        for (int i = 0; i < 20; i++) begin
            mask = 4'($urandom_range(1, 15));
            sw   = 16'($urandom);
            if (mask[2]) begin
                exec(mask, $urandom_range(1, 8), 16'($urandom));
            end else begin
                if (mask[0]) m_op = (m_op + 1) % 8;
                if (mask[1]) begin m_a = sw[15:8]; m_b = sw[7:0]; end
                if (mask[3]) m_mode = !m_mode;
                press(mask, TAIL);
                check_state("rand");
            end
        end

`ifdef DEBOUNCE_EN
        // Short glitch is rejected, a held press counts once
        @(negedge clk); btn = 4'b0001;
        repeat (3) @(negedge clk); btn = '0;
        repeat (12) @(negedge clk);
        check_eq("db_glitch", 32'(alu_op), 32'(m_op));
        btn = 4'b0001;
        repeat (10) @(negedge clk); btn = '0;
        repeat (12) @(negedge clk);
        m_op = (m_op + 1) % 8;
        check_eq("db_hold", 32'(alu_op), 32'(m_op));
`endif

        // Reset in the middle of WAIT aborts to reset values
        alu_lat = -1;
        press(4'b0100, 0);
        wait_busy(1'b1, 20 + PX);
        repeat (5) @(negedge clk);
        check_eq("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        m_op = 0; m_a = '0; m_b = '0; m_res = '0; m_err = 0; m_mode = 0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_start", 32'(alu_start), 32'd0);
        check_state("abort");
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (4) @(negedge clk);
        check_eq("abort_no_start", 32'(start_cnt - s0), 32'd0);
        check_eq("abort_idle", 32'(busy), 32'd0);
        check_state("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
